// File: rtl/nexus_nonce_scheduler_if.sv
// Handshake bundle between a nonce scheduler and its work/result agent.
//   master : drives work loading, issue enable, lane hits and result pop
//   slave  : the scheduler; returns issued nonces, result FIFO head and status
// Lane i nonce occupies NonceOut[64*i +: 64].
interface nexus_nonce_scheduler_if #(
  parameter int unsigned LANES = 2
);
  logic                  WorkValid;
  logic [63:0]           BaseNonce;
  logic                  Enable;
  logic [64*LANES-1:0]   NonceOut;
  logic                  IssueValid;
  logic [LANES-1:0]      LaneHit;
  logic [63:0]           ResultNonce;
  logic                  ResultValid;
  logic                  ResultReady;
  logic                  Overflow;
  logic                  PipeFull;

  modport master (
    output WorkValid, BaseNonce, Enable, LaneHit, ResultReady,
    input  NonceOut, IssueValid, ResultNonce, ResultValid, Overflow, PipeFull
  );

  modport slave (
    input  WorkValid, BaseNonce, Enable, LaneHit, ResultReady,
    output NonceOut, IssueValid, ResultNonce, ResultValid, Overflow, PipeFull
  );
endinterface

// File: rtl/nexus_nonce_scheduler.sv
// Nonce issuer and result collector for LANES parallel hash pipelines of depth LATENCY.
// Each enabled cycle hands a distinct nonce to every lane; hits returning LATENCY cycles
// later are qualified by a valid shift line and their nonces are rebuilt from a retire
// counter, then queued in a small first-word-fall-through FIFO.
// Ports:
//   clk       : clock, rising edge
//   nHashRst  : asynchronous active-low reset
//   bus       : slave modport carrying WorkValid/BaseNonce/Enable (work control),
//               NonceOut/IssueValid (issue), LaneHit (pipeline hits),
//               ResultNonce/ResultValid/ResultReady (result FIFO), Overflow, PipeFull
module nexus_nonce_scheduler #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned LATENCY    = 391,
  parameter int unsigned CORES      = 1,
  parameter int unsigned COREIDX    = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   nHashRst,
  nexus_nonce_scheduler_if.slave bus
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam logic [63:0] Stride = 64'(CORES * LANES);
  localparam logic [63:0] Offset = 64'(COREIDX * LANES);
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  // Issue side
  logic [63:0]         issueCnt;
  logic [64*LANES-1:0] nonceOutQ;
  logic                issueValidQ;
  logic [63:0]         laneIssue [LANES];

  // Retire side
  logic [LATENCY-1:0]  validLine;
  logic [LATENCY-1:0]  validNext;
  logic                retireTap;
  logic [63:0]         retireCnt;
  logic [63:0]         laneRetire [LANES];
  logic                pipeFullQ;

  // Result FIFO
  logic [63:0]         fifoMem [FIFO_DEPTH];
  logic [PtrW-1:0]     rdPtr;
  logic [PtrW-1:0]     wrPtr;
  logic [CntW-1:0]     count;
  logic                overflowQ;
  logic                popReq;
  logic [LANES-1:0]    hitQual;
  logic [CntW-1:0]     space;
  logic [CntW-1:0]     nPush;
  logic                drop;
  logic [LANES-1:0]    laneWr;
  logic [PtrW-1:0]     laneSlot [LANES];

  genvar g;
  for (g = 0; g < LANES; g++) begin : gLane
    assign laneIssue[g]  = issueCnt + 64'(g);
    assign laneRetire[g] = retireCnt + 64'(g);
  end

  // Issue counter and registered lane nonces. WorkValid suppresses the issue in its cycle.
  always_ff @(posedge clk or negedge nHashRst) begin
    if (!nHashRst) begin
      issueCnt    <= '0;
      nonceOutQ   <= '0;
      issueValidQ <= 1'b0;
    end else if (bus.WorkValid) begin
      issueCnt    <= bus.BaseNonce + Offset;
      issueValidQ <= 1'b0;
    end else if (bus.Enable) begin
      issueCnt    <= issueCnt + Stride;
      issueValidQ <= 1'b1;
      for (int i = 0; i < LANES; i++) begin
        nonceOutQ[64*i +: 64] <= laneIssue[i];
      end
    end else begin
      issueValidQ <= 1'b0;
    end
  end

  // The oldest bit of the line lines up with the LaneHit of the matching issue.
  assign retireTap = validLine[LATENCY-1];
  assign validNext = {validLine[LATENCY-2:0], issueValidQ};

  // Retire counter advances only on live slots, so bubbles never consume a nonce.
  // PipeFull is the AND of the line after the shift: LATENCY live issues in a row.
  always_ff @(posedge clk or negedge nHashRst) begin
    if (!nHashRst) begin
      validLine <= '0;
      retireCnt <= '0;
      pipeFullQ <= 1'b0;
    end else if (bus.WorkValid) begin
      validLine <= '0;
      retireCnt <= bus.BaseNonce + Offset;
      pipeFullQ <= 1'b0;
    end else begin
      validLine <= validNext;
      pipeFullQ <= &validNext;
      if (retireTap) begin
        retireCnt <= retireCnt + Stride;
      end
    end
  end

  assign popReq  = (count != '0) & bus.ResultReady;
  assign hitQual = bus.LaneHit & {LANES{retireTap}};

  // Allocate FIFO slots to qualified lanes in ascending order; a same-cycle pop
  // frees one extra slot. Lanes that find no room are dropped.
  always_comb begin
    space  = DepthC - count + CntW'(popReq);
    nPush  = '0;
    drop   = 1'b0;
    laneWr = '0;
    for (int i = 0; i < LANES; i++) begin
      laneSlot[i] = wrPtr + nPush[PtrW-1:0];
      if (hitQual[i]) begin
        if (nPush < space) begin
          laneWr[i] = 1'b1;
          nPush     = nPush + CntW'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nHashRst) begin
    if (!nHashRst) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      overflowQ <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifoMem[k] <= '0;
      end
    end else if (bus.WorkValid) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      overflowQ <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (laneWr[i]) begin
          fifoMem[laneSlot[i]] <= laneRetire[i];
        end
      end
      wrPtr <= wrPtr + nPush[PtrW-1:0];
      if (popReq) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      count <= count + nPush - CntW'(popReq);
      if (drop) begin
        overflowQ <= 1'b1;
      end
    end
  end

  assign bus.NonceOut    = nonceOutQ;
  assign bus.IssueValid  = issueValidQ;
  assign bus.ResultNonce = fifoMem[rdPtr];
  assign bus.ResultValid = (count != '0);
  assign bus.Overflow    = overflowQ;
  assign bus.PipeFull    = pipeFullQ;

endmodule
